// File: rtl/square_wave_period_meter.sv
// Schmitt-triggered square-wave meter: measures high time and full period in audio
// sample ticks and publishes each completed cycle with a one-clk valid strobe.
module square_wave_period_meter #(
  parameter logic signed [15:0] THRESH_HIGH     = 16'sd10923,
  parameter logic signed [15:0] THRESH_LOW      = 16'sd5461,
  parameter int                 COUNT_WIDTH     = 24,
  parameter int                 TIMEOUT_SAMPLES = 48000
) (
  input  logic                    clk,
  input  logic                    I_RSTn,
  input  logic                    audio_clk_en,
  input  logic signed [15:0]      in,
  output logic [COUNT_WIDTH-1:0]  high_time,
  output logic [COUNT_WIDTH-1:0]  period,
  output logic                    valid,
  output logic                    stalled
);

  localparam logic [COUNT_WIDTH-1:0] ONE     = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT = COUNT_WIDTH'(TIMEOUT_SAMPLES);

  typedef enum logic [1:0] {SYNC, HIGH, LOW} state_t;

  state_t                 state_reg;
  logic                   level_reg;
  logic [COUNT_WIDTH-1:0] hi_cnt_reg;
  logic [COUNT_WIDTH-1:0] lo_cnt_reg;

  logic                   rise_edge;
  logic                   fall_edge;
  logic [COUNT_WIDTH-1:0] hi_inc;
  logic [COUNT_WIDTH-1:0] lo_inc;
  logic [COUNT_WIDTH:0]   sum_wide;
  logic [COUNT_WIDTH-1:0] period_sat;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  // Edges are only meaningful on sample ticks; both operands are signed.
  assign rise_edge = audio_clk_en && !level_reg && (in >= THRESH_HIGH);
  assign fall_edge = audio_clk_en &&  level_reg && (in <= THRESH_LOW);

  assign hi_inc     = sat_inc(hi_cnt_reg);
  assign lo_inc     = sat_inc(lo_cnt_reg);
  assign sum_wide   = {1'b0, hi_cnt_reg} + {1'b0, lo_cnt_reg};
  assign period_sat = sum_wide[COUNT_WIDTH] ? {COUNT_WIDTH{1'b1}} : sum_wide[COUNT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!I_RSTn) begin
      state_reg  <= SYNC;
      level_reg  <= 1'b0;
      hi_cnt_reg <= '0;
      lo_cnt_reg <= '0;
      high_time  <= '0;
      period     <= '0;
      valid      <= 1'b0;
      stalled    <= 1'b1;
    end else begin
      valid <= 1'b0;
      if (audio_clk_en) begin
        if (rise_edge)
          level_reg <= 1'b1;
        else if (fall_edge)
          level_reg <= 1'b0;

        case (state_reg)
          SYNC: begin
            if (rise_edge) begin
              hi_cnt_reg <= ONE;
              lo_cnt_reg <= '0;
              state_reg  <= HIGH;
            end
          end
          HIGH: begin
            if (fall_edge) begin
              lo_cnt_reg <= ONE;
              state_reg  <= LOW;
            end else if (hi_inc >= TIMEOUT) begin
              stalled    <= 1'b1;
              high_time  <= '0;
              period     <= '0;
              hi_cnt_reg <= '0;
              lo_cnt_reg <= '0;
              state_reg  <= SYNC;
            end else begin
              hi_cnt_reg <= hi_inc;
            end
          end
          LOW: begin
            if (rise_edge) begin
              high_time  <= hi_cnt_reg;
              period     <= period_sat;
              valid      <= 1'b1;
              stalled    <= 1'b0;
              hi_cnt_reg <= ONE;
              lo_cnt_reg <= '0;
              state_reg  <= HIGH;
            end else if (lo_inc >= TIMEOUT) begin
              stalled    <= 1'b1;
              high_time  <= '0;
              period     <= '0;
              hi_cnt_reg <= '0;
              lo_cnt_reg <= '0;
              state_reg  <= SYNC;
            end else begin
              lo_cnt_reg <= lo_inc;
            end
          end
          default: state_reg <= SYNC;
        endcase
      end
    end
  end

endmodule
